// File: rtl/systolic_mm_core.sv
// N x N output-stationary systolic array: streams K columns of A and rows of B, accumulates C = A*B in place.
// Define SYSTOLIC_MM_SAT_EN for saturating accumulators and the sticky ovf output.
module systolic_mm_core #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 40,
    parameter int KW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    input  logic [N*DW-1:0]          a_vec,
    input  logic [N*DW-1:0]          b_vec,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    input  logic [$clog2(N*N)-1:0]   rd_addr,
    output logic [AW-1:0]            rd_data
`ifdef SYSTOLIC_MM_SAT_EN
    ,
    output logic                     ovf
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for start after reset
    // S_FEED  | accepting k-steps until k_len transfers seen
    // S_DRAIN | flushing the skewed wavefront through the grid (2N-1 cycles)
    // S_DONE  | results stable and readable until next start
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    localparam int RAW = $clog2(N*N);
    localparam int DCW = $clog2(2*N);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2*N-2);

    state_t          r_state, w_next;
    logic [KW-1:0]   r_klen, r_kcnt, w_kcnt_nxt;
    logic [DCW-1:0]  r_dcnt;
    logic            w_start_acc, w_xfer;

    logic signed [DW-1:0] r_ska  [N][N];
    logic signed [DW-1:0] r_skb  [N][N];
    logic                 r_skav [N][N];
    logic                 r_skbv [N][N];
    logic signed [DW-1:0] r_pa   [N][N];
    logic signed [DW-1:0] r_pb   [N][N];
    logic                 r_pav  [N][N];
    logic                 r_pbv  [N][N];
    logic signed [AW-1:0] r_acc  [N][N];
    logic [AW-1:0]        r_rd_data;

    logic signed [DW-1:0] w_a_row [N];
    logic signed [DW-1:0] w_b_col [N];
    logic                 w_av_row [N];
    logic                 w_bv_col [N];
    logic signed [DW-1:0] w_ain  [N][N];
    logic signed [DW-1:0] w_bin  [N][N];
    logic                 w_ainv [N][N];
    logic                 w_binv [N][N];
    logic                 w_en   [N][N];
    logic signed [AW-1:0] w_acc_nxt [N][N];
    logic [AW-1:0]        w_flat [2**RAW];
`ifdef SYSTOLIC_MM_SAT_EN
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    logic w_sat_any;
    logic r_ovf;
`endif

    assign w_start_acc = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_xfer      = in_valid && (r_state == S_FEED);
    assign w_kcnt_nxt  = r_kcnt + KW'(1);
    assign in_ready    = (r_state == S_FEED);
    assign busy        = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign rd_data     = r_rd_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = (k_len == '0) ? S_DONE : S_FEED;
            S_FEED:         if (w_xfer && (w_kcnt_nxt == r_klen)) w_next = S_DRAIN;
            S_DRAIN:        if (r_dcnt == '0) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_klen  <= '0;
            r_kcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_acc) begin
                r_klen <= k_len;
                r_kcnt <= '0;
            end else if (w_xfer) begin
                r_kcnt <= w_kcnt_nxt;
            end
            if (r_state == S_FEED && w_next == S_DRAIN)
                r_dcnt <= DRAIN_LAST;
            else if (r_state == S_DRAIN && r_dcnt != '0)
                r_dcnt <= r_dcnt - DCW'(1);
        end
    end

    // Row/column 0 bypasses the skew chain; row i taps stage i-1 of its chain.
    always_comb begin
        logic signed [2*DW-1:0] w_mul;
        logic signed [AW-1:0]   w_ext;
`ifdef SYSTOLIC_MM_SAT_EN
        logic signed [AW:0]     w_sum;
        w_sum     = '0;
        w_sat_any = 1'b0;
`endif
        w_mul = '0;
        w_ext = '0;
        for (int i = 0; i < N; i++) begin
            w_a_row[i]  = (i == 0) ? a_vec[i*DW +: DW] : r_ska[i][(i > 0) ? i-1 : 0];
            w_av_row[i] = (i == 0) ? w_xfer : r_skav[i][(i > 0) ? i-1 : 0];
            w_b_col[i]  = (i == 0) ? b_vec[i*DW +: DW] : r_skb[i][(i > 0) ? i-1 : 0];
            w_bv_col[i] = (i == 0) ? w_xfer : r_skbv[i][(i > 0) ? i-1 : 0];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_ain[i][j]  = (j == 0) ? w_a_row[i]  : r_pa[i][(j > 0) ? j-1 : 0];
                w_ainv[i][j] = (j == 0) ? w_av_row[i] : r_pav[i][(j > 0) ? j-1 : 0];
                w_bin[i][j]  = (i == 0) ? w_b_col[j]  : r_pb[(i > 0) ? i-1 : 0][j];
                w_binv[i][j] = (i == 0) ? w_bv_col[j] : r_pbv[(i > 0) ? i-1 : 0][j];
                w_en[i][j]   = w_ainv[i][j] && w_binv[i][j];
                w_mul = (2*DW)'(w_ain[i][j]) * (2*DW)'(w_bin[i][j]);
                w_ext = AW'(w_mul);
`ifdef SYSTOLIC_MM_SAT_EN
                w_sum = (AW+1)'(r_acc[i][j]) + (AW+1)'(w_ext);
                if (w_sum[AW] != w_sum[AW-1]) begin
                    w_acc_nxt[i][j] = w_sum[AW] ? ACC_MIN : ACC_MAX;
                    if (w_en[i][j]) w_sat_any = 1'b1;
                end else begin
                    w_acc_nxt[i][j] = w_sum[AW-1:0];
                end
`else
                w_acc_nxt[i][j] = r_acc[i][j] + w_ext;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_ska[i][j] <= '0;  r_skav[i][j] <= 1'b0;
                    r_skb[i][j] <= '0;  r_skbv[i][j] <= 1'b0;
                    r_pa[i][j]  <= '0;  r_pav[i][j]  <= 1'b0;
                    r_pb[i][j]  <= '0;  r_pbv[i][j]  <= 1'b0;
                    r_acc[i][j] <= '0;
                end
            end
        end else if (w_start_acc) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_ska[i][j] <= '0;  r_skav[i][j] <= 1'b0;
                    r_skb[i][j] <= '0;  r_skbv[i][j] <= 1'b0;
                    r_pa[i][j]  <= '0;  r_pav[i][j]  <= 1'b0;
                    r_pb[i][j]  <= '0;  r_pbv[i][j]  <= 1'b0;
                    r_acc[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < N; s++) begin
                    if (s < i) begin
                        if (s == 0) begin
                            r_ska[i][0]  <= a_vec[i*DW +: DW];
                            r_skav[i][0] <= w_xfer;
                            r_skb[i][0]  <= b_vec[i*DW +: DW];
                            r_skbv[i][0] <= w_xfer;
                        end else begin
                            r_ska[i][s]  <= r_ska[i][(s > 0) ? s-1 : 0];
                            r_skav[i][s] <= r_skav[i][(s > 0) ? s-1 : 0];
                            r_skb[i][s]  <= r_skb[i][(s > 0) ? s-1 : 0];
                            r_skbv[i][s] <= r_skbv[i][(s > 0) ? s-1 : 0];
                        end
                    end
                end
                for (int j = 0; j < N; j++) begin
                    r_pa[i][j]  <= w_ain[i][j];
                    r_pav[i][j] <= w_ainv[i][j];
                    r_pb[i][j]  <= w_bin[i][j];
                    r_pbv[i][j] <= w_binv[i][j];
                    if (w_en[i][j]) r_acc[i][j] <= w_acc_nxt[i][j];
                end
            end
        end
    end

    // Unused addresses beyond N*N read as zero.
    always_comb begin
        for (int a = 0; a < 2**RAW; a++) w_flat[a] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                w_flat[i*N+j] = r_acc[i][j];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_data <= '0;
        else      r_rd_data <= w_flat[rd_addr];
    end

`ifdef SYSTOLIC_MM_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             r_ovf <= 1'b0;
        else if (w_start_acc) r_ovf <= 1'b0;
        else if (w_sat_any)   r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_systolic_mm_core.sv
// Self-checking bench for systolic_mm_core: directed and random jobs against an arithmetic matrix model.
// Follows SYSTOLIC_MM_SAT_EN for the expected accumulator behaviour and the ovf port.
module tb_systolic_mm_core;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int KW  = 8;
    localparam int RAW = $clog2(N*N);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [KW-1:0]    k_len = '0;
    logic [N*DW-1:0]  a_vec = '0;
    logic [N*DW-1:0]  b_vec = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, busy, done;
    logic [RAW-1:0]   rd_addr = '0;
    logic [AW-1:0]    rd_data;
`ifdef SYSTOLIC_MM_SAT_EN
    logic             ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [N*DW-1:0] qa[$];
    logic [N*DW-1:0] qb[$];
    logic [AW-1:0]   exp_c [N*N];
    bit              exp_ovf;

    systolic_mm_core #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_vec(a_vec), .b_vec(b_vec), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef SYSTOLIC_MM_SAT_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] a_elem(int dmode, int k, int i);
        case (dmode)
            1:       return (i == k) ? DW'(1) : DW'(0);
            2:       return DW'(-2);
            3:       return DW'(5);
            4:       return {1'b1, {(DW-1){1'b0}}};
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [DW-1:0] b_elem(int dmode, int k, int j);
        case (dmode)
            1:       return DW'(k*N + j + 1);
            2:       return DW'(3);
            3:       return DW'(5);
            4:       return {1'b1, {(DW-1){1'b0}}};
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic longint sx(logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // C[i][j] = sum over accepted k-steps of A[i][k]*B[k][j], wrapped or clamped per step.
    task automatic compute_expected();
        longint maxv = (longint'(1) <<< (AW-1)) - 1;
        longint minv = -(longint'(1) <<< (AW-1));
        logic [N*DW-1:0] av, bv;
        exp_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint acc = 0;
                for (int k = 0; k < qa.size(); k++) begin
                    av = qa[k];
                    bv = qb[k];
                    acc = acc + sx(av[i*DW +: DW]) * sx(bv[j*DW +: DW]);
`ifdef SYSTOLIC_MM_SAT_EN
                    if (acc > maxv) begin acc = maxv; exp_ovf = 1'b1; end
                    if (acc < minv) begin acc = minv; exp_ovf = 1'b1; end
`endif
                end
                exp_c[i*N+j] = acc[AW-1:0];
            end
        end
    endtask

    task automatic start_job(int k);
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        qa.delete();
        qb.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    // vmode: 0 always valid, 1 alternate 1,0,1,..., 2 random.
    task automatic feed(int k, int vmode, int dmode, bit pulse);
        int sent = 0;
        int cyc = 0;
        bit v;
        logic [N*DW-1:0] av, bv;
        while (sent < k && cyc < 2000) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL feed_in_ready: cyc %0d got %b expected 1", cyc, in_ready);
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            for (int i = 0; i < N; i++) begin
                av[i*DW +: DW] = v ? a_elem(dmode, sent, i) : DW'($urandom);
                bv[i*DW +: DW] = v ? b_elem(dmode, sent, i) : DW'($urandom);
            end
            a_vec = av;
            b_vec = bv;
            in_valid = v;
            start = pulse && (cyc == 1);
            if (pulse) k_len = KW'(7);
            if (v) begin
                qa.push_back(av);
                qb.push_back(bv);
                sent++;
            end
            cyc++;
            if (sent < k) @(negedge clk);
        end
        vectors++;
        if (sent != k) begin
            miscompares++;
            $display("FAIL feed_timeout: sent %0d expected %0d", sent, k);
        end
    endtask

    task automatic readout(string name);
        rd_addr = '0;
        for (int a = 0; a < N*N; a++) begin
            @(negedge clk);
            vectors++;
            if (rd_data !== exp_c[a]) begin
                miscompares++;
                $display("FAIL %s_rd[%0d]: got %0d expected %0d", name, a,
                         $signed(rd_data), $signed(exp_c[a]));
            end
            rd_addr = RAW'(a + 1);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_persist: got %b expected 1", name, done);
        end
`ifdef SYSTOLIC_MM_SAT_EN
        vectors++;
        if (ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s_ovf: got %b expected %b", name, ovf, exp_ovf);
        end
`endif
    endtask

    // DONE must appear on the 2N-th falling edge after the last transfer was driven.
    task automatic finish_job(string name);
        compute_expected();
        for (int c = 1; c <= 2*N; c++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            a_vec = {$urandom, $urandom};
            b_vec = {$urandom, $urandom};
            vectors++;
            if (c < 2*N) begin
                if ({busy, done, in_ready} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL %s_drain c%0d: busy/done/rdy got %b expected 100", name, c,
                             {busy, done, in_ready});
                end
            end else if ({busy, done, in_ready} !== 3'b010) begin
                miscompares++;
                $display("FAIL %s_latency: busy/done/rdy got %b expected 010", name,
                         {busy, done, in_ready});
            end
        end
        in_valid = 1'b0;
        readout(name);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({in_ready, busy, done} !== 3'b000 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rdy/busy/done %b rd_data %0h expected 000 0",
                     {in_ready, busy, done}, rd_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected 000", {in_ready, busy, done});
        end
    endtask

    task automatic test_identity();
        start_job(4);
        feed(4, 0, 1, 1'b0);
        finish_job("identity");
    endtask

    task automatic test_bubbles();
        start_job(3);
        feed(3, 1, 2, 1'b0);
        finish_job("bubbles");
    endtask

    task automatic test_k_zero();
        start_job(0);
        vectors++;
        if ({busy, done, in_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL kzero_state: busy/done/rdy got %b expected 010", {busy, done, in_ready});
        end
        compute_expected();
        readout("kzero");
    endtask

    task automatic test_start_ignored();
        start_job(2);
        feed(2, 2, 0, 1'b1);
        finish_job("start_ignored");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            start_job($urandom_range(1, 12));
            feed(int'(k_len), 2, 0, 1'b0);
            finish_job("random");
        end
    endtask

    task automatic test_reset_mid();
        start_job(4);
        feed(4, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, in_ready} !== 3'b000 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_abort: busy/done/rdy %b rd_data %0h expected 000 0",
                     {busy, done, in_ready}, rd_data);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, in_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_idle: busy/done/rdy got %b expected 000", {busy, done, in_ready});
        end
        start_job(1);
        feed(1, 0, 3, 1'b0);
        finish_job("after_reset");
    endtask

    task automatic test_saturate();
        start_job(200);
        feed(200, 0, 4, 1'b0);
        finish_job("saturate");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bubbles();
        test_k_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_mm_core.md
SYSTOLIC_MM_CORE -- requirements
Module: systolic_mm_core

Interface
REQ-001 Parameter N, default 4: PE grid is N rows x N columns (2..8).
REQ-002 Parameter DW, default 16: signed operand width.
REQ-003 Parameter AW, default 40: signed accumulator/result width, at least 2*DW.
REQ-004 Parameter KW, default 8: width of k_len; maximum inner dimension is 2^KW-1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle pulse that begins a multiply job.
REQ-008 k_len  input  KW  inner dimension K, sampled when start is accepted.
REQ-009 a_vec  input  N*DW  column k of A; row i occupies bits [i*DW +: DW].
REQ-010 b_vec  input  N*DW  row k of B; column j occupies bits [j*DW +: DW].
REQ-011 in_valid  input  1  a_vec/b_vec carry a valid k-step.
REQ-012 in_ready  output  1  core accepts a k-step this cycle.
REQ-013 busy  output  1  job in progress (FEED or DRAIN).
REQ-014 done  output  1  level; results stable and readable.
REQ-015 rd_addr  input  clog2(N*N)  result index i*N+j.
REQ-016 rd_data  output  AW  C[i][j], registered.

Function
REQ-017 FSM states IDLE, FEED, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE/DONE + start: clear all accumulators and skew registers, latch k_len, go to FEED; if k_len=0 go directly to DONE with all results 0.
REQ-019 start in FEED or DRAIN is ignored.
REQ-020 in_ready is 1 only in FEED; a k-step is transferred when in_valid and in_ready are both 1.
REQ-021 in_valid low in FEED inserts a bubble: valid tag 0 propagates, no accumulation, no data loss.
REQ-022 Row i of A enters PE(i,0) after an i-cycle skew delay; column j of B enters PE(0,j) after a j-cycle skew delay; each operand carries a valid tag.
REQ-023 PE(i,j) accumulates acc += a*b (signed, product sign-extended to AW) only when both incoming tags are 1, and forwards a right and b down with their tags, one-cycle register each.
REQ-024 After the K-th transfer, FSM enters DRAIN for exactly 2N-1 cycles, then DONE.
REQ-025 Total latency: DONE is entered 2N-1 cycles after the cycle of the last transfer.
REQ-026 busy = 1 in FEED and DRAIN; done = 1 only in DONE.
REQ-027 rd_data = acc[rd_addr] registered one cycle after rd_addr; valid in DONE; rd_addr >= N*N returns 0.
REQ-028 Results persist in DONE until the next accepted start.
REQ-029 Internal k counter counts transfers and wraps never; FEED exits exactly when count = latched k_len.

Reset
REQ-030 rst low asynchronously forces: state IDLE, in_ready 0, busy 0, done 0, rd_data 0, all accumulators, skew and tag registers 0, k counter 0.
REQ-031 rst asserted mid-job aborts the job; after release the core waits in IDLE for a new start.
REQ-032 rst release is sampled synchronously; first start is accepted on the first clk edge with rst high.

Configuration
REQ-033 Macro SYSTOLIC_MM_SAT_EN: when defined, each accumulator saturates at the signed AW-bit max/min instead of wrapping.
REQ-034 With SYSTOLIC_MM_SAT_EN defined, output ovf (1 bit, after done) is a sticky flag set if any PE saturated in the current job, cleared on start and reset.
REQ-035 Without SYSTOLIC_MM_SAT_EN, accumulators wrap modulo 2^AW and port ovf does not exist.

Verification
REQ-036 N=4, K=4, A=identity, B[k][j]=k*4+j+1, in_valid held 1 -> done 7 cycles after 4th transfer; C[i][j]=i*4+j+1 read at all 16 addresses.
REQ-037 N=4, K=3, all A=-2, all B=3, in_valid toggled 1,0,1,0,1 -> 3 transfers only, every C = -18.
REQ-038 start with k_len=0 -> DONE next cycle, busy never 1, all rd_data = 0.
REQ-039 rst low during DRAIN of a K=4 job -> done 0, busy 0 immediately; new K=1 job with A=B=all 5 -> every C = 25.
REQ-040 SYSTOLIC_MM_SAT_EN defined, AW=32, DW=16, K=200, A=B=-32768 -> C saturates at 2147483647, ovf 1; undefined -> C = 200*2^30 mod 2^32 interpreted signed (0), no ovf port.
REQ-041 start pulsed during FEED of K=2 job -> ignored; job completes with results of the first job only.
